pipelined_rca_addsub: RTL and testbench

//  Parametrised, pipelined ripple-carry adder/subtractor. It is the successor to the 4-bit combinational

---
 rtl/pipelined_rca_addsub_if.sv | 28 ++
 rtl/pipelined_rca_addsub.sv | 90 +++++++++
 tb/tb_pipelined_rca_addsub.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_rca_addsub_if.sv
// Operand/result handshake bundle for the pipelined ripple-carry adder/subtractor.
// The slave side is the adder; the master side is whoever drives operands and takes results.
interface pipelined_rca_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [WIDTH:0]   finalsum;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, finalsum
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, finalsum
  );
endinterface

// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor: operands are captured at acceptance, then the carry
// chain is split into STAGES equal slices, each followed by a register (latency = STAGES edges).
module pipelined_rca_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_rca_addsub_if.slave io_bus
);
  localparam int CHUNK = WIDTH / STAGES;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             cTop;
  } slice_t;

  // Index 0 is the operand capture stage; index k+1 holds the result of slice k.
  logic [WIDTH-1:0] r_a   [0:STAGES-1];
  logic [WIDTH-1:0] r_b   [0:STAGES-1];
  logic [WIDTH-1:0] r_s   [1:STAGES];
  logic             r_c   [0:STAGES];
  logic             r_v   [0:STAGES];
  logic             r_ovf;

  slice_t           w_slice [0:STAGES-1];
  logic             w_advance;

  // Ripple one CHUNK of full-adder cells; cTop is the carry entering the slice's top bit.
  function automatic slice_t sliceAdd(input logic [WIDTH-1:0] aIn, input logic [WIDTH-1:0] bIn,
                                      input logic [WIDTH-1:0] sIn, input logic cIn, input int k);
    slice_t res;
    logic   carry;
    res.sum  = sIn;
    res.cTop = cIn;
    carry    = cIn;
    for (int i = 0; i < CHUNK; i++) begin
      res.cTop               = carry;
      res.sum[k*CHUNK + i]   = aIn[k*CHUNK + i] ^ bIn[k*CHUNK + i] ^ carry;
      carry                  = (aIn[k*CHUNK + i] & bIn[k*CHUNK + i]) |
                               (carry & (aIn[k*CHUNK + i] ^ bIn[k*CHUNK + i]));
    end
    res.cout = carry;
    return res;
  endfunction

  assign w_advance = !r_v[STAGES] || io_bus.out_ready;

  always_comb begin
    w_slice[0] = sliceAdd(r_a[0], r_b[0], '0, r_c[0], 0);
    for (int k = 1; k < STAGES; k++) begin
      w_slice[k] = sliceAdd(r_a[k], r_b[k], r_s[k], r_c[k], k);
    end
  end

  // Whole pipe moves together or not at all, so bubbles stay where they are.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '{default: '0};
      r_b   <= '{default: '0};
      r_s   <= '{default: '0};
      r_c   <= '{default: 1'b0};
      r_v   <= '{default: 1'b0};
      r_ovf <= 1'b0;
    end else if (w_advance) begin
      r_v[0] <= io_bus.in_valid;
      r_a[0] <= io_bus.a;
      r_b[0] <= io_bus.sub ? ~io_bus.b : io_bus.b;
      r_c[0] <= io_bus.sub ? ~io_bus.cin : io_bus.cin;
      for (int k = 1; k < STAGES; k++) begin
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        r_v[k+1] <= r_v[k];
        r_s[k+1] <= w_slice[k].sum;
        r_c[k+1] <= w_slice[k].cout;
      end
      r_ovf <= w_slice[STAGES-1].cTop ^ w_slice[STAGES-1].cout;
    end
  end

  assign io_bus.in_ready  = w_advance;
  assign io_bus.out_valid = r_v[STAGES];
  assign io_bus.sum       = r_s[STAGES];
  assign io_bus.cout      = r_c[STAGES];
  assign io_bus.ovf       = r_ovf;
  assign io_bus.finalsum  = {r_c[STAGES], r_s[STAGES]};
endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Scoreboard bench for pipelined_rca_addsub: a STAGES=4 instance carries the main traffic,
// STAGES=1 and STAGES=16 instances repeat the basic add to confirm their latency.
module tb_pipelined_rca_addsub;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_rca_addsub_if #(.WIDTH(W)) bus4  ();
  pipelined_rca_addsub_if #(.WIDTH(W)) bus1  ();
  pipelined_rca_addsub_if #(.WIDTH(W)) bus16 ();

  pipelined_rca_addsub #(.WIDTH(W), .STAGES(4))  dut4  (.clk(clk), .rst(rst), .io_bus(bus4.slave));
  pipelined_rca_addsub #(.WIDTH(W), .STAGES(1))  dut1  (.clk(clk), .rst(rst), .io_bus(bus1.slave));
  pipelined_rca_addsub #(.WIDTH(W), .STAGES(16)) dut16 (.clk(clk), .rst(rst), .io_bus(bus16.slave));

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
    bit           chkLat;
  } exp_t;

  exp_t sbQ[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;
  logic gOutReady;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cycle);
    end
  endtask

  function automatic exp_t modelOp(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
    exp_t       e;
    logic [W-1:0] bE;
    logic       cE;
    logic [W:0] full;
    bE       = sub ? ~b : b;
    cE       = sub ? ~cin : cin;
    full     = {1'b0, a} + {1'b0, bE} + {{W{1'b0}}, cE};
    e.sum    = full[W-1:0];
    e.cout   = full[W];
    e.ovf    = (a[W-1] == bE[W-1]) && (full[W-1] != a[W-1]);
    e.acc    = 0;
    e.chkLat = 1'b0;
    return e;
  endfunction

  function automatic exp_t mkExp(input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum    = s;
    e.cout   = c;
    e.ovf    = o;
    e.acc    = 0;
    e.chkLat = 1'b1;
    return e;
  endfunction

  // One cycle: drive at negedge, then score the handshakes the coming posedge will perform.
  task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub, input exp_t e, output bit accepted);
    exp_t ent;
    exp_t front;
    ent = e;
    @(negedge clk);
    bus4.in_valid  = v;
    bus4.a         = a;
    bus4.b         = b;
    bus4.cin       = cin;
    bus4.sub       = sub;
    bus4.out_ready = gOutReady;
    #1;
    accepted = 1'b0;
    if (!rst) begin
      if (bus4.out_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_out", bus4.out_valid, 0);
        end else begin
          front = sbQ[0];
          checkOutput("sum", bus4.sum, front.sum);
          checkOutput("cout", bus4.cout, front.cout);
          checkOutput("ovf", bus4.ovf, front.ovf);
          checkOutput("finalsum", bus4.finalsum, {front.cout, front.sum});
          if (bus4.out_ready) begin
            // Output seen in this cycle was launched by the edge before it.
            if (front.chkLat) checkOutput("latency", cycle - front.acc - 1, 4);
            void'(sbQ.pop_front());
          end else begin
            checkOutput("in_ready_stall", bus4.in_ready, 0);
          end
        end
      end
      if (v && bus4.in_ready) begin
        ent.acc = cycle;
        sbQ.push_back(ent);
        accepted = 1'b1;
      end
    end
    cycle++;
  endtask

  task automatic idle(input int n);
    bit   acc;
    exp_t none;
    none = mkExp('0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, none, acc);
  endtask

  initial begin
    bit           acc;
    exp_t         e;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           stallStart;
    int           tries;
    int           found1, found16;

    rst = 1'b1;
    gOutReady = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0; bus4.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0; bus1.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus16.out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    checkOutput("rst_out_valid", bus4.out_valid, 0);
    checkOutput("rst_in_ready", bus4.in_ready, 1);
    checkOutput("rst_finalsum", bus4.finalsum, 0);
    checkOutput("rst_ovf", bus4.ovf, 0);

    applyStimulus(1'b1, 16'h1234, 16'h0FCC, 1'b0, 1'b0, mkExp(16'h2200, 1'b0, 1'b0), acc);
    checkOutput("accept_t1", acc, 1);
    idle(6);

    applyStimulus(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, mkExp(16'h0000, 1'b1, 1'b0), acc);
    applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, mkExp(16'hFFFE, 1'b0, 1'b0), acc);
    applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, mkExp(16'h7FFF, 1'b1, 1'b1), acc);
    applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, mkExp(16'h8000, 1'b0, 1'b1), acc);
    idle(6);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      e = modelOp(ra, rb, rc, rs);
      e.chkLat = 1'b1;
      applyStimulus(1'b1, ra, rb, rc, rs, e, acc);
      checkOutput("accept_stream", acc, 1);
    end
    idle(6);

    // Producer holds each op until it is taken while the consumer stalls for 5 cycles.
    stallStart = cycle + 8;
    for (int i = 0; i < 15; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      e = modelOp(ra, rb, rc, rs);
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
        gOutReady = !(cycle >= stallStart && cycle < stallStart + 5);
        applyStimulus(1'b1, ra, rb, rc, rs, e, acc);
        tries++;
      end
      checkOutput("bp_accept", acc, 1);
    end
    gOutReady = 1'b1;
    tries = 0;
    while (sbQ.size() != 0 && tries < 30) begin
      idle(1);
      tries++;
    end
    checkOutput("bp_drain_empty", sbQ.size(), 0);

    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      applyStimulus(1'b1, ra, rb, 1'b0, 1'b0, modelOp(ra, rb, 1'b0, 1'b0), acc);
    end
    rst = 1'b1;
    idle(1);
    sbQ.delete();
    checkOutput("mid_rst_valid", bus4.out_valid, 0);
    checkOutput("mid_rst_finalsum", bus4.finalsum, 0);
    checkOutput("mid_rst_cout", bus4.cout, 0);
    checkOutput("mid_rst_ovf", bus4.ovf, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      checkOutput("post_rst_valid", bus4.out_valid, 0);
      checkOutput("post_rst_in_ready", bus4.in_ready, 1);
    end

    @(negedge clk);
    bus1.in_valid = 1'b1;  bus1.a = 16'h1234;  bus1.b = 16'h0FCC;
    bus16.in_valid = 1'b1; bus16.a = 16'h1234; bus16.b = 16'h0FCC;
    #1;
    checkOutput("s1_in_ready", bus1.in_ready, 1);
    checkOutput("s16_in_ready", bus16.in_ready, 1);
    found1 = -1;
    found16 = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bus1.in_valid = 1'b0;
      bus16.in_valid = 1'b0;
      #1;
      if (bus1.out_valid && found1 < 0) begin
        found1 = n - 1;
        checkOutput("s1_finalsum", bus1.finalsum, 17'h02200);
        checkOutput("s1_ovf", bus1.ovf, 0);
      end
      if (bus16.out_valid && found16 < 0) begin
        found16 = n - 1;
        checkOutput("s16_finalsum", bus16.finalsum, 17'h02200);
        checkOutput("s16_ovf", bus16.ovf, 0);
      end
    end
    checkOutput("s1_latency", found1, 1);
    checkOutput("s16_latency", found16, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
